// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory read port between icache and dcache.
// Serialises transactions, forces one MRead-low cycle between them, and aborts hung reads.
module mem_arbiter #(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IAddr,
  input  logic        IRead,
  output logic [31:0] IData,
  output logic        IRdy,
  input  logic [31:0] DAddr,
  input  logic        DRead,
  output logic [31:0] DData,
  output logic        DRdy,
  output logic [31:0] MAddr,
  input  logic [31:0] MData,
  output logic        MRead,
  input  logic        MRdy,
  output logic [1:0]  Gnt,
  output logic        Err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RELEASE} state_t;

  state_t           state, state_d;
  logic             last_owner, last_d;   // 1: dcache was served last
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [31:0]      maddr_d, idata_d, ddata_d, rsp_data;
  logic             mread_d, irdy_d, drdy_d, err_d, pick_d;
  logic [1:0]       gnt_d;
  logic             owner_is_d, owner_read;

  assign owner_is_d = (state == BUSY_D);
  assign owner_read = owner_is_d ? DRead : IRead;

  always_comb begin
    state_d  = state;
    last_d   = last_owner;
    cnt_d    = cnt;
    maddr_d  = MAddr;
    mread_d  = MRead;
    gnt_d    = Gnt;
    idata_d  = IData;
    ddata_d  = DData;
    irdy_d   = 1'b0;
    drdy_d   = 1'b0;
    err_d    = Err;
    pick_d   = 1'b0;
    rsp_data = ERR_DATA;

    case (state)
      IDLE: begin
        // dcache wins when alone, or on a tie when icache was served last
        pick_d = DRead && (!IRead || !last_owner);
        if (IRead || DRead) begin
          maddr_d = pick_d ? DAddr : IAddr;
          mread_d = 1'b1;
          gnt_d   = pick_d ? 2'b10 : 2'b01;
          cnt_d   = '0;
          state_d = pick_d ? BUSY_D : BUSY_I;
        end
      end

      BUSY_I, BUSY_D: begin
        if (MRdy || !owner_read || cnt == CNT_LAST) begin
          mread_d = 1'b0;
          gnt_d   = 2'b00;
          last_d  = owner_is_d;
          state_d = RELEASE;
          // Still requested without MRdy here means the watchdog fired
          if (MRdy || owner_read) begin
            rsp_data = MRdy ? MData : ERR_DATA;
            err_d    = Err | !MRdy;
            if (owner_is_d) begin
              ddata_d = rsp_data;
              drdy_d  = 1'b1;
            end else begin
              idata_d = rsp_data;
              irdy_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end

      RELEASE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      cnt        <= '0;
      MAddr      <= '0;
      MRead      <= 1'b0;
      Gnt        <= 2'b00;
      IData      <= '0;
      DData      <= '0;
      IRdy       <= 1'b0;
      DRdy       <= 1'b0;
      Err        <= 1'b0;
    end else begin
      state      <= state_d;
      last_owner <= last_d;
      cnt        <= cnt_d;
      MAddr      <= maddr_d;
      MRead      <= mread_d;
      Gnt        <= gnt_d;
      IData      <= idata_d;
      DData      <= ddata_d;
      IRdy       <= irdy_d;
      DRdy       <= drdy_d;
      Err        <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: transaction-level reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_mem_arbiter;

  localparam int          TO   = 8;
  localparam logic [31:0] ERRD = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IAddr, DAddr, IData, DData, MAddr;
  logic        IRead, DRead, IRdy, DRdy, MRead, Err;
  logic [31:0] MData = 32'h0;
  logic        MRdy  = 1'b0;
  logic [1:0]  Gnt;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERRD)) dut (
    .clk(clk), .reset(reset),
    .IAddr(IAddr), .IRead(IRead), .IData(IData), .IRdy(IRdy),
    .DAddr(DAddr), .DRead(DRead), .DData(DData), .DRdy(DRdy),
    .MAddr(MAddr), .MData(MData), .MRead(MRead), .MRdy(MRdy),
    .Gnt(Gnt), .Err(Err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memval(input logic [31:0] a);
    return (a == 32'h10) ? 32'h00500113 : (a ^ 32'h5A5A0000);
  endfunction

  // Main memory: answers after mem_lat cycles of MRead, or never when hung
  int mem_lat  = 4;
  bit mem_hang = 1'b0;
  initial begin
    int mem_cnt;
    mem_cnt = 0;
    forever begin
      @(negedge clk);
      if (MRead) begin
        mem_cnt++;
        if (!mem_hang && mem_cnt == mem_lat) begin
          MRdy  = 1'b1;
          MData = memval(MAddr);
        end else begin
          MRdy  = 1'b0;
          MData = 32'hDEAD0000 | 32'(mem_cnt);
        end
      end else begin
        mem_cnt = 0;
        MRdy    = 1'b0;
      end
    end
  end

  // Reference model: phase 0 idle, 1 serving m_owner (1=I, 2=D), 2 release
  bit          m_valid = 1'b0;
  logic [31:0] e_maddr, e_idata, e_ddata;
  logic        e_mread, e_irdy, e_drdy, e_err;
  logic [1:0]  e_gnt;
  initial begin
    int  m_phase, m_owner, m_last, m_waited, want;
    bit  still, done;
    m_phase = 0; m_owner = 0; m_last = 2; m_waited = 0;
    forever begin
      @(posedge clk);
      e_irdy = 1'b0;
      e_drdy = 1'b0;
      if (reset) begin
        m_phase = 0; m_last = 2; m_waited = 0;
        e_maddr = '0; e_mread = 1'b0; e_gnt = 2'b00;
        e_idata = '0; e_ddata = '0; e_err = 1'b0;
        m_valid = 1'b1;
      end else if (m_phase == 0) begin
        want = 0;
        if (IRead && DRead) want = 3 - m_last;
        else if (IRead)     want = 1;
        else if (DRead)     want = 2;
        if (want != 0) begin
          m_owner  = want;
          e_maddr  = (want == 1) ? IAddr : DAddr;
          e_mread  = 1'b1;
          e_gnt    = 2'(want);
          m_waited = 0;
          m_phase  = 1;
        end
      end else if (m_phase == 1) begin
        still = (m_owner == 1) ? IRead : DRead;
        m_waited++;
        done = 1'b1;
        if (MRdy) begin
          if (m_owner == 1) begin e_idata = MData; e_irdy = 1'b1; end
          else              begin e_ddata = MData; e_drdy = 1'b1; end
        end else if (!still) begin
          done = 1'b1;
        end else if (m_waited == TO) begin
          e_err = 1'b1;
          if (m_owner == 1) begin e_idata = ERRD; e_irdy = 1'b1; end
          else              begin e_ddata = ERRD; e_drdy = 1'b1; end
        end else begin
          done = 1'b0;
        end
        if (done) begin
          e_mread = 1'b0;
          e_gnt   = 2'b00;
          m_last  = m_owner;
          m_phase = 2;
        end
      end else begin
        m_phase = 0;
      end
    end
  end

  // Per-cycle compare plus a small transaction log
  int          irdy_cnt = 0;
  int          drdy_cnt = 0;
  logic [1:0]  gq_gnt[$];
  logic [31:0] gq_addr[$];
  initial begin
    logic prev_mread;
    prev_mread = 1'b0;
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("cmp_MRead", 32'(MRead), 32'(e_mread));
        chk("cmp_MAddr", MAddr, e_maddr);
        chk("cmp_Gnt",   32'(Gnt), 32'(e_gnt));
        chk("cmp_IRdy",  32'(IRdy), 32'(e_irdy));
        chk("cmp_DRdy",  32'(DRdy), 32'(e_drdy));
        chk("cmp_IData", IData, e_idata);
        chk("cmp_DData", DData, e_ddata);
        chk("cmp_Err",   32'(Err), 32'(e_err));
        chk("rdy_excl",  32'(IRdy & DRdy), 32'd0);
        if (MRead && !prev_mread) begin
          gq_gnt.push_back(Gnt);
          gq_addr.push_back(MAddr);
        end
        if (IRdy) irdy_cnt++;
        if (DRdy) drdy_cnt++;
        prev_mread = MRead;
      end
    end
  end

  task automatic wait_rdy(input int who, input int maxc, output logic [31:0] d, output int n);
    d = '0;
    n = -1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (who == 1 && IRdy) begin d = IData; n = i + 1; return; end
      if (who == 2 && DRdy) begin d = DData; n = i + 1; return; end
    end
  endtask

  task automatic wait_any(input int maxc, output int who, output logic [31:0] d);
    who = 0;
    d   = '0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (IRdy) begin who = 1; d = IData; return; end
      if (DRdy) begin who = 2; d = DData; return; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [31:0] d;
    int          n, who, expw;

    reset = 1'b1; IRead = 1'b0; DRead = 1'b0; IAddr = '0; DAddr = '0;
    repeat (3) @(negedge clk);
    chk("rst_mread", 32'(MRead), 32'd0);
    chk("rst_maddr", MAddr, 32'd0);
    chk("rst_gnt",   32'(Gnt), 32'd0);
    chk("rst_err",   32'(Err), 32'd0);
    chk("rst_irdy",  32'(IRdy), 32'd0);
    reset = 1'b0;

    // Single icache request
    mem_lat = 6;
    @(negedge clk);
    IAddr = 32'h10; IRead = 1'b1;
    @(negedge clk);
    chk("t1_mread_rise", 32'(MRead), 32'd1);
    chk("t1_maddr", MAddr, 32'h10);
    chk("t1_gnt", 32'(Gnt), 32'd1);
    wait_rdy(1, 20, d, n);
    chk("t1_latency", n, 32'd6);
    chk("t1_idata", d, 32'h00500113);
    chk("t1_mread_low", 32'(MRead), 32'd0);
    IRead = 1'b0;
    @(negedge clk);
    chk("t1_irdy_once", 32'(IRdy), 32'd0);
    chk("t1_mread_low2", 32'(MRead), 32'd0);

    // Tie after reset, both held: I, D, I, D
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    gq_gnt.delete(); gq_addr.delete();
    mem_lat = 3;
    IAddr = 32'h20; DAddr = 32'h80; IRead = 1'b1; DRead = 1'b1;
    expw = 1;
    for (int k = 0; k < 4; k++) begin
      wait_any(20, who, d);
      chk("t2_order", who, expw);
      chk("t2_data", d, memval((expw == 1) ? 32'h20 : 32'h80));
      expw = 3 - expw;
    end
    IRead = 1'b0; DRead = 1'b0;
    chk("t2_grants", gq_addr.size(), 32'd4);
    if (gq_addr.size() >= 2) begin
      chk("t2_g1_gnt", 32'(gq_gnt[1]), 32'd2);
      chk("t2_g1_addr", gq_addr[1], 32'h80);
    end

    // Held IRead with address stepping after each IRdy
    @(negedge clk);
    irdy_cnt = 0;
    gq_gnt.delete(); gq_addr.delete();
    mem_lat = 2;
    IAddr = 32'h10; IRead = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_rdy(1, 20, d, n);
      chk("t3_rdy_seen", 32'(n > 0), 32'd1);
      chk("t3_data", d, memval(32'h10 + 32'(4 * k)));
      if (k < 2) IAddr = IAddr + 32'd4;
      else       IRead = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("t3_irdy_count", irdy_cnt, 32'd3);
    chk("t3_grants", gq_addr.size(), 32'd3);
    for (int k = 0; k < 3; k++)
      if (k < gq_addr.size()) chk("t3_addr", gq_addr[k], 32'h10 + 32'(4 * k));

    // Abort: DRead dropped three cycles into BUSY_D, pending IRead follows
    mem_hang = 1'b1;
    drdy_cnt = 0;
    DAddr = 32'h40; DRead = 1'b1;
    @(negedge clk);
    chk("t4_gnt_d", 32'(Gnt), 32'd2);
    chk("t4_maddr_d", MAddr, 32'h40);
    IAddr = 32'h24; IRead = 1'b1;
    repeat (2) @(negedge clk);
    DRead = 1'b0;
    @(negedge clk);
    chk("t4_mread_fall", 32'(MRead), 32'd0);
    chk("t4_gnt_none", 32'(Gnt), 32'd0);
    chk("t4_err", 32'(Err), 32'd0);
    mem_hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_gnt_i", 32'(Gnt), 32'd1);
    chk("t4_maddr_i", MAddr, 32'h24);
    wait_rdy(1, 20, d, n);
    chk("t4_idata", d, memval(32'h24));
    IRead = 1'b0;
    chk("t4_no_drdy", drdy_cnt, 32'd0);

    // Timeout on a hung memory, then a normal transaction
    @(negedge clk);
    mem_hang = 1'b1;
    IAddr = 32'h30; IRead = 1'b1;
    wait_rdy(1, 20, d, n);
    chk("t5_latency", n, 32'd9);
    chk("t5_data", d, ERRD);
    chk("t5_err", 32'(Err), 32'd1);
    IRead = 1'b0;
    mem_hang = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_err_sticky", 32'(Err), 32'd1);
    DAddr = 32'h44; DRead = 1'b1;
    wait_rdy(2, 20, d, n);
    chk("t5_next_data", d, memval(32'h44));
    chk("t5_err_after", 32'(Err), 32'd1);
    DRead = 1'b0;

    // Reset in the middle of BUSY_D
    @(negedge clk);
    mem_hang = 1'b1;
    drdy_cnt = 0;
    DAddr = 32'h50; DRead = 1'b1;
    @(negedge clk);
    chk("t6_gnt_d", 32'(Gnt), 32'd2);
    @(negedge clk);
    reset = 1'b1;
    IAddr = 32'h60; IRead = 1'b1;
    @(negedge clk);
    chk("t6_mread", 32'(MRead), 32'd0);
    chk("t6_gnt", 32'(Gnt), 32'd0);
    chk("t6_err", 32'(Err), 32'd0);
    chk("t6_drdy", 32'(DRdy), 32'd0);
    mem_hang = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    chk("t6_gnt_i", 32'(Gnt), 32'd1);
    chk("t6_maddr_i", MAddr, 32'h60);
    wait_rdy(1, 20, d, n);
    chk("t6_idata", d, memval(32'h60));
    chk("t6_no_drdy", drdy_cnt, 32'd0);
    IRead = 1'b0;
    wait_rdy(2, 20, d, n);
    chk("t6_ddata", d, memval(32'h50));
    DRead = 1'b0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
